// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_pkg
// Purpose  : Shared definitions for the stack engine: 4-bit op encodings,
//            error-code constants and a per-op depth requirement helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package stack_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSH  = 4'h1;
  localparam logic [3:0] OP_POP   = 4'h2;
  localparam logic [3:0] OP_DUP   = 4'h3;
  localparam logic [3:0] OP_SWAP  = 4'h4;
  localparam logic [3:0] OP_ROT   = 4'h5;
  localparam logic [3:0] OP_REPL2 = 4'h6;
  localparam logic [3:0] OP_REPL1 = 4'h7;
  localparam logic [3:0] OP_RPUSH = 4'h8;
  localparam logic [3:0] OP_RPOP  = 4'h9;
  localparam logic [3:0] OP_RCP   = 4'hA;
  localparam logic [3:0] OP_RLIT  = 4'hB;
  localparam logic [3:0] OP_RDROP = 4'hC;
  localparam logic [3:0] OP_CLEAR = 4'hD;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_ILL  = 2'd3;

  // Inclusive bounds on data depth (d) and return depth (r) before the op.
  typedef struct packed {
    int min_d;
    int max_d;
    int min_r;
    int max_r;
  } op_req_t;

  function automatic op_req_t op_req(input logic [3:0] op, input int depth,
                                     input int rdepth);
    op_req_t q;
    q.min_d = 0;
    q.max_d = depth;
    q.min_r = 0;
    q.max_r = rdepth;
    case (op)
      OP_PUSH:  q.max_d = depth - 1;
      OP_POP:   q.min_d = 1;
      OP_DUP:   begin q.min_d = 1; q.max_d = depth - 1; end
      OP_SWAP:  q.min_d = 2;
      OP_ROT:   q.min_d = 3;
      OP_REPL2: q.min_d = 2;
      OP_REPL1: q.min_d = 1;
      OP_RPUSH: begin q.min_d = 1; q.max_r = rdepth - 1; end
      OP_RPOP:  begin q.min_r = 1; q.max_d = depth - 1; end
      OP_RCP:   begin q.min_r = 1; q.max_d = depth - 1; end
      OP_RLIT:  q.max_r = rdepth - 1;
      OP_RDROP: q.min_r = 1;
      default:  ;
    endcase
    return q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem
// Purpose  : Register-array LIFO with entry counter and TAPS read taps
//            (tap 0 = top). Unfilled taps read 0. No bounds checking here.
// Ports    : clk, rst_n          clock, async active-low reset
//            push_i/push_data_i  write at count, count+1
//            pop_i               count-1
//            wr_top/sec/thd_i    overwrite entry count-1/-2/-3 (pre-op count)
//            clear_i             count to 0
//            depth_o, taps_o     entry count, flattened read taps
// Revision : 1.0 - initial release
// ============================================================================
module stack_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int TAPS  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          push_data_i,
  input  logic                      pop_i,
  input  logic                      wr_top_i,
  input  logic                      wr_sec_i,
  input  logic                      wr_thd_i,
  input  logic [WIDTH-1:0]          top_data_i,
  input  logic [WIDTH-1:0]          sec_data_i,
  input  logic [WIDTH-1:0]          thd_data_i,
  input  logic                      clear_i,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic [TAPS*WIDTH-1:0]     taps_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)              cnt_d = '0;
    else if (push_i && !pop_i) cnt_d = cnt_q + CW'(1);
    else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Storage needs no reset: entries above the count are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_i   && CW'(i) == cnt_q)           mem_q[i] <= push_data_i;
      if (wr_top_i && CW'(i) == cnt_q - CW'(1))  mem_q[i] <= top_data_i;
      if (wr_sec_i && CW'(i) == cnt_q - CW'(2))  mem_q[i] <= sec_data_i;
      if (wr_thd_i && CW'(i) == cnt_q - CW'(3))  mem_q[i] <= thd_data_i;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic [WIDTH-1:0] tap;
    always_comb begin
      tap = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_q > CW'(k) && CW'(i) == cnt_q - CW'(k + 1)) tap = mem_q[i];
      end
    end
    assign taps_o[k*WIDTH +: WIDTH] = tap;
  end

  assign depth_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/stack_engine.sv
`default_nettype none
// ============================================================================
// Module   : stack_engine
// Purpose  : Data/return stack unit. One op per accepted valid/ready
//            transfer; requirement checks and sticky error live here.
// Ports    : clk, rst_n             clock, async active-low reset
//            op_valid/op_ready/op   request handshake and op code
//            din                    operand (PUSH/REPL1/REPL2/RLIT)
//            tos/nos/ros, rtos      top data entries, top return entry
//            depth, rdepth          entry counts
//            err, err_code, err_clr sticky error, its cause, clear pulse
// Revision : 1.0 - initial release
// ============================================================================
module stack_engine
  import stack_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int RDEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic [3:0]                  op,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            tos,
  output logic [WIDTH-1:0]            nos,
  output logic [WIDTH-1:0]            ros,
  output logic [WIDTH-1:0]            rtos,
  output logic [$clog2(DEPTH+1)-1:0]  depth,
  output logic [$clog2(RDEPTH+1)-1:0] rdepth,
  output logic                        err,
  output logic [1:0]                  err_code,
  input  logic                        err_clr
);

  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [3*WIDTH-1:0] d_taps;
  logic [WIDTH-1:0] r_taps;

  logic             d_push, d_pop, d_wtop, d_wsec, d_wthd, r_push, r_pop, clr;
  logic [WIDTH-1:0] d_push_data, d_top_data, d_sec_data, d_thd_data, r_push_data;
  logic             accept, illegal, unf, ovf;
  op_req_t          req;

  assign tos  = d_taps[WIDTH-1:0];
  assign nos  = d_taps[2*WIDTH-1:WIDTH];
  assign ros  = d_taps[3*WIDTH-1:2*WIDTH];
  assign rtos = r_taps;

  always_comb begin
    d_push = 1'b0; d_pop = 1'b0; d_wtop = 1'b0; d_wsec = 1'b0; d_wthd = 1'b0;
    r_push = 1'b0; r_pop = 1'b0; clr = 1'b0;
    d_push_data = din; d_top_data = din; d_sec_data = din; d_thd_data = din;
    r_push_data = din;

    accept  = op_valid && !err_q;
    req     = op_req(op, DEPTH, RDEPTH);
    illegal = (op == 4'hE) || (op == 4'hF);
    unf     = (int'(depth) < req.min_d) || (int'(rdepth) < req.min_r);
    ovf     = (int'(depth) > req.max_d) || (int'(rdepth) > req.max_r);

    err_d      = err_q;
    err_code_d = err_code_q;
    // A new error beats a simultaneous clear.
    if (accept && (illegal || unf || ovf)) begin
      err_d      = 1'b1;
      err_code_d = illegal ? ERR_ILL : (unf ? ERR_UNF : ERR_OVF);
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end

    if (accept && !(illegal || unf || ovf)) begin
      case (op)
        OP_PUSH:  d_push = 1'b1;
        OP_POP:   d_pop  = 1'b1;
        OP_DUP:   begin d_push = 1'b1; d_push_data = tos; end
        OP_SWAP:  begin d_wtop = 1'b1; d_top_data = nos; d_wsec = 1'b1; d_sec_data = tos; end
        OP_ROT:   begin
          d_wtop = 1'b1; d_top_data = ros;
          d_wsec = 1'b1; d_sec_data = tos;
          d_wthd = 1'b1; d_thd_data = nos;
        end
        // Old second becomes the new top after the pop.
        OP_REPL2: begin d_pop = 1'b1; d_wsec = 1'b1; end
        OP_REPL1: d_wtop = 1'b1;
        OP_RPUSH: begin d_pop = 1'b1; r_push = 1'b1; r_push_data = tos; end
        OP_RPOP:  begin r_pop = 1'b1; d_push = 1'b1; d_push_data = rtos; end
        OP_RCP:   begin d_push = 1'b1; d_push_data = rtos; end
        OP_RLIT:  r_push = 1'b1;
        OP_RDROP: r_pop  = 1'b1;
        OP_CLEAR: clr    = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
  assign op_ready = !err_q;

  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAPS(3)) u_dstack (
    .clk(clk), .rst_n(rst_n),
    .push_i(d_push), .push_data_i(d_push_data), .pop_i(d_pop),
    .wr_top_i(d_wtop), .wr_sec_i(d_wsec), .wr_thd_i(d_wthd),
    .top_data_i(d_top_data), .sec_data_i(d_sec_data), .thd_data_i(d_thd_data),
    .clear_i(clr), .depth_o(depth), .taps_o(d_taps)
  );

  stack_mem #(.WIDTH(WIDTH), .DEPTH(RDEPTH), .TAPS(1)) u_rstack (
    .clk(clk), .rst_n(rst_n),
    .push_i(r_push), .push_data_i(r_push_data), .pop_i(r_pop),
    .wr_top_i(1'b0), .wr_sec_i(1'b0), .wr_thd_i(1'b0),
    .top_data_i('0), .sec_data_i('0), .thd_data_i('0),
    .clear_i(clr), .depth_o(rdepth), .taps_o(r_taps)
  );

endmodule
`default_nettype wire

// File: tb/tb_stack_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_engine
// Purpose  : Directed self-checking bench for stack_engine (16x16 config).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_engine;
  import stack_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  op = 4'h0;
  logic [15:0] din = '0;
  logic [15:0] tos, nos, ros, rtos;
  logic [4:0]  depth, rdepth;
  logic        err;
  logic [1:0]  err_code;
  logic        err_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_engine #(.WIDTH(16), .DEPTH(16), .RDEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .din(din), .tos(tos), .nos(nos), .ros(ros), .rtos(rtos),
    .depth(depth), .rdepth(rdepth), .err(err), .err_code(err_code),
    .err_clr(err_clr)
  );

  task automatic issue(input logic [3:0] o, input logic [15:0] d);
    op_valid = 1'b1; op = o; din = d;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (depth !== 5'd0) begin $display("FAIL reset_depth got %0d want 0", depth); fails++; end
    tests++; if (rdepth !== 5'd0) begin $display("FAIL reset_rdepth got %0d want 0", rdepth); fails++; end
    tests++; if (err !== 1'b0 || err_code !== 2'd0) begin $display("FAIL reset_err got %b/%0d want 0/0", err, err_code); fails++; end
    tests++; if (op_ready !== 1'b1) begin $display("FAIL reset_ready got %b want 1", op_ready); fails++; end
    tests++; if ({tos, nos, ros, rtos} !== 64'd0) begin $display("FAIL reset_taps got %h %h %h %h want 0", tos, nos, ros, rtos); fails++; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_repl2();
    issue(OP_PUSH, 16'd5);
    issue(OP_PUSH, 16'd7);
    issue(OP_REPL2, 16'd12);
    tests++; if (depth !== 5'd1) begin $display("FAIL repl2_depth got %0d want 1", depth); fails++; end
    tests++; if (tos !== 16'd12) begin $display("FAIL repl2_tos got %0d want 12", tos); fails++; end
    tests++; if (nos !== 16'd0) begin $display("FAIL repl2_nos got %0d want 0", nos); fails++; end
    tests++; if (err !== 1'b0) begin $display("FAIL repl2_err got %b want 0", err); fails++; end
    issue(OP_REPL1, 16'h00AB);
    tests++; if (tos !== 16'h00AB || depth !== 5'd1) begin $display("FAIL repl1 got tos=%h d=%0d want 00ab/1", tos, depth); fails++; end
    issue(OP_CLEAR, 16'd0);
  endtask

  task automatic test_rot_swap();
    issue(OP_PUSH, 16'd1);
    issue(OP_PUSH, 16'd2);
    issue(OP_PUSH, 16'd3);
    issue(OP_ROT, 16'd0);
    tests++; if ({tos, nos, ros} !== {16'd1, 16'd3, 16'd2} || depth !== 5'd3) begin
      $display("FAIL rot got %0d %0d %0d d=%0d want 1 3 2 d=3", tos, nos, ros, depth); fails++; end
    issue(OP_SWAP, 16'd0);
    tests++; if ({tos, nos, ros} !== {16'd3, 16'd1, 16'd2}) begin
      $display("FAIL swap got %0d %0d %0d want 3 1 2", tos, nos, ros); fails++; end
    issue(OP_DUP, 16'd0);
    tests++; if ({tos, nos, ros} !== {16'd3, 16'd3, 16'd1} || depth !== 5'd4) begin
      $display("FAIL dup got %0d %0d %0d d=%0d want 3 3 1 d=4", tos, nos, ros, depth); fails++; end
    issue(OP_POP, 16'd0);
    tests++; if (tos !== 16'd3 || nos !== 16'd1 || depth !== 5'd3) begin
      $display("FAIL pop got %0d %0d d=%0d want 3 1 d=3", tos, nos, depth); fails++; end
    issue(OP_CLEAR, 16'd0);
    tests++; if (depth !== 5'd0 || tos !== 16'd0) begin $display("FAIL clear got d=%0d tos=%0d want 0 0", depth, tos); fails++; end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) issue(OP_PUSH, 16'(i));
    tests++; if (depth !== 5'd16 || err !== 1'b0) begin $display("FAIL full_depth got d=%0d err=%b want 16/0", depth, err); fails++; end
    issue(OP_PUSH, 16'd99);
    tests++; if (err !== 1'b1 || err_code !== ERR_OVF) begin $display("FAIL ovf_err got %b/%0d want 1/1", err, err_code); fails++; end
    tests++; if (depth !== 5'd16 || tos !== 16'd15) begin $display("FAIL ovf_state got d=%0d tos=%0d want 16/15", depth, tos); fails++; end
    tests++; if (op_ready !== 1'b0) begin $display("FAIL ovf_ready got %b want 0", op_ready); fails++; end
    issue(OP_POP, 16'd0);
    tests++; if (depth !== 5'd16 || err_code !== ERR_OVF) begin $display("FAIL ignored got d=%0d code=%0d want 16/1", depth, err_code); fails++; end
    clear_err();
    tests++; if (op_ready !== 1'b1 || err !== 1'b0 || err_code !== 2'd0) begin
      $display("FAIL clr got rdy=%b err=%b code=%0d want 1 0 0", op_ready, err, err_code); fails++; end
    issue(OP_POP, 16'd0);
    tests++; if (tos !== 16'd14 || depth !== 5'd15) begin $display("FAIL pop_after got tos=%0d d=%0d want 14/15", tos, depth); fails++; end
    // Refill to DEPTH, then RPOP with r=0: underflow outranks overflow.
    issue(OP_PUSH, 16'd77);
    issue(OP_RPOP, 16'd0);
    tests++; if (err_code !== ERR_UNF || depth !== 5'd16) begin $display("FAIL prio got code=%0d d=%0d want 2/16", err_code, depth); fails++; end
    clear_err();
    // Erroring op and err_clr together: the error wins.
    err_clr = 1'b1;
    issue(OP_DUP, 16'd0);
    err_clr = 1'b0;
    tests++; if (err !== 1'b1 || err_code !== ERR_OVF || depth !== 5'd16) begin
      $display("FAIL clr_vs_err got %b/%0d d=%0d want 1/1 d=16", err, err_code, depth); fails++; end
    clear_err();
    issue(OP_CLEAR, 16'd0);
  endtask

  task automatic test_underflow_illegal();
    issue(OP_POP, 16'd0);
    tests++; if (err_code !== ERR_UNF || depth !== 5'd0) begin $display("FAIL unf got code=%0d d=%0d want 2/0", err_code, depth); fails++; end
    clear_err();
    issue(4'hE, 16'd0);
    tests++; if (err_code !== ERR_ILL || err !== 1'b1) begin $display("FAIL ill got code=%0d err=%b want 3/1", err_code, err); fails++; end
    clear_err();
    issue(OP_RDROP, 16'd0);
    tests++; if (err_code !== ERR_UNF || rdepth !== 5'd0) begin $display("FAIL rdrop_unf got code=%0d r=%0d want 2/0", err_code, rdepth); fails++; end
    clear_err();
    issue(OP_NOP, 16'd0);
    tests++; if (err !== 1'b0 || depth !== 5'd0) begin $display("FAIL nop got err=%b d=%0d want 0/0", err, depth); fails++; end
  endtask

  task automatic test_return();
    issue(OP_RLIT, 16'h1234);
    issue(OP_PUSH, 16'd9);
    issue(OP_RPUSH, 16'd0);
    issue(OP_RCP, 16'd0);
    tests++; if (rdepth !== 5'd2 || rtos !== 16'd9) begin $display("FAIL rcp_r got r=%0d rtos=%h want 2/0009", rdepth, rtos); fails++; end
    tests++; if (depth !== 5'd1 || tos !== 16'd9) begin $display("FAIL rcp_d got d=%0d tos=%h want 1/0009", depth, tos); fails++; end
    issue(OP_RDROP, 16'd0);
    tests++; if (rtos !== 16'h1234 || rdepth !== 5'd1) begin $display("FAIL rdrop got rtos=%h r=%0d want 1234/1", rtos, rdepth); fails++; end
    issue(OP_RPOP, 16'd0);
    tests++; if (rdepth !== 5'd0 || rtos !== 16'd0) begin $display("FAIL rpop_r got r=%0d rtos=%h want 0/0000", rdepth, rtos); fails++; end
    tests++; if (tos !== 16'h1234 || nos !== 16'd9 || depth !== 5'd2) begin
      $display("FAIL rpop_d got tos=%h nos=%h d=%0d want 1234/0009/2", tos, nos, depth); fails++; end
    issue(OP_CLEAR, 16'd0);
  endtask

  task automatic test_async_reset();
    issue(OP_PUSH, 16'd1);
    issue(OP_PUSH, 16'd2);
    issue(OP_RLIT, 16'd3);
    op_valid = 1'b1; op = OP_PUSH; din = 16'd4;
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (depth !== 5'd0 || rdepth !== 5'd0 || err !== 1'b0) begin
      $display("FAIL async_rst got d=%0d r=%0d err=%b want 0 0 0", depth, rdepth, err); fails++; end
    tests++; if (tos !== 16'd0) begin $display("FAIL async_tos got %0d want 0", tos); fails++; end
    @(posedge clk); #1;
    tests++; if (depth !== 5'd0) begin $display("FAIL rst_hold got d=%0d want 0", depth); fails++; end
    op_valid = 1'b0;
    rst_n = 1'b1;
    issue(OP_PUSH, 16'd42);
    tests++; if (tos !== 16'd42 || depth !== 5'd1) begin $display("FAIL post_rst got tos=%0d d=%0d want 42/1", tos, depth); fails++; end
  endtask

  initial begin
    test_reset();
    test_repl2();
    test_rot_swap();
    test_overflow();
    test_underflow_illegal();
    test_return();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
